// File: rtl/wb4_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone B4 slave among several masters, held per bus cycle.
// Latency: one cycle from a CYC request in IDLE to the grant; request, ack and read-data paths are combinational.
// Backpressure: the owner sees slave STALL and also stalls at MAXPENDING outstanding; every other master is stalled.
module wb4_arbiter #(
    parameter int ARCHBITSZ   = 32,
    parameter int MASTERCOUNT = 4,
    parameter int MAXPENDING  = 4
) (
    input  logic                               wb4_clk_i,
    input  logic                               wb4_rst_i,
    input  logic [MASTERCOUNT-1:0]             m_cyc_i,
    input  logic [MASTERCOUNT-1:0]             m_stb_i,
    input  logic [MASTERCOUNT-1:0]             m_we_i,
    input  logic [MASTERCOUNT*ARCHBITSZ-1:0]   m_addr_i,
    input  logic [MASTERCOUNT*ARCHBITSZ-1:0]   m_data_i,
    input  logic [MASTERCOUNT*(ARCHBITSZ/8)-1:0] m_sel_i,
    output logic [MASTERCOUNT-1:0]             m_stall_o,
    output logic [MASTERCOUNT-1:0]             m_ack_o,
    output logic [ARCHBITSZ-1:0]               m_data_o,
    output logic                               s_cyc_o,
    output logic                               s_stb_o,
    output logic                               s_we_o,
    output logic [ARCHBITSZ-1:0]               s_addr_o,
    output logic [ARCHBITSZ-1:0]               s_data_o,
    output logic [ARCHBITSZ/8-1:0]             s_sel_o,
    input  logic                               s_stall_i,
    input  logic                               s_ack_i,
    input  logic [ARCHBITSZ-1:0]               s_data_i
);

    localparam int SELW = ARCHBITSZ / 8;
    localparam int GW   = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;
    localparam int PW   = $clog2(MAXPENDING + 1);

    localparam logic [PW-1:0] PEND_MAX = PW'(MAXPENDING);
    localparam logic [GW-1:0] LAST_RST = GW'(MASTERCOUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] gnt, gnt_nxt;
    logic [GW-1:0] last, last_nxt;
    logic [PW-1:0] pend, pend_nxt;

    logic                 pend_full;
    logic                 ack_ev;
    logic                 accept;
    logic [GW-1:0]        rr_idx;
    logic                 rr_hit;
    logic                 g_cyc, g_stb, g_we;
    logic [ARCHBITSZ-1:0] g_addr, g_data;
    logic [SELW-1:0]      g_sel;

    assign pend_full = (pend == PEND_MAX);
    // An ack with nothing outstanding is spurious and must never change pend or reach a master.
    assign ack_ev    = s_ack_i && (pend != '0);

    // Request fields of the currently granted master.
    always_comb begin
        g_cyc  = m_cyc_i[gnt];
        g_stb  = m_stb_i[gnt];
        g_we   = m_we_i[gnt];
        g_addr = m_addr_i[int'(gnt)*ARCHBITSZ +: ARCHBITSZ];
        g_data = m_data_i[int'(gnt)*ARCHBITSZ +: ARCHBITSZ];
        g_sel  = m_sel_i[int'(gnt)*SELW +: SELW];
    end

    // Round-robin search: first CYC requester after the last owner, wrapping around.
    always_comb begin
        int idx;
        idx    = 0;
        rr_idx = '0;
        rr_hit = 1'b0;
        for (int i = 1; i <= MASTERCOUNT; i++) begin
            idx = int'(last) + i;
            if (idx >= MASTERCOUNT) begin
                idx = idx - MASTERCOUNT;
            end
            if (!rr_hit && m_cyc_i[GW'(idx)]) begin
                rr_hit = 1'b1;
                rr_idx = GW'(idx);
            end
        end
    end

    // A request is accepted when it is presented to the slave and the slave does not stall it.
    assign accept = (state == ST_GRANT) && g_cyc && g_stb && !pend_full && !s_stall_i;

    // Outstanding-request count: accepts increment, real acks decrement.
    always_comb begin
        pend_nxt = pend;
        case ({accept, ack_ev})
            2'b10:   pend_nxt = pend + 1'b1;
            2'b01:   pend_nxt = pend - 1'b1;
            default: pend_nxt = pend;
        endcase
    end

    // Next-state and bus-side outputs of the ownership FSM.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        m_stall_o = '1;
        m_ack_o   = '0;
        case (state)
            ST_IDLE: begin
                if (rr_hit) begin
                    gnt_nxt   = rr_idx;
                    last_nxt  = rr_idx;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                s_we_o         = g_we;
                m_stall_o[gnt] = s_stall_i || pend_full;
                m_ack_o[gnt]   = ack_ev;
                if (g_cyc) begin
                    s_cyc_o = 1'b1;
                    s_stb_o = g_stb && !pend_full;
                end else begin
                    // Owner released the bus: drain leftovers before anyone else is granted.
                    state_nxt = (pend_nxt == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Keep CYC up so the slave can finish; acks are absorbed here.
                s_cyc_o = 1'b1;
                if (pend_nxt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Address, write data and selects follow the granted master; forced to zero while in reset.
    always_comb begin
        s_addr_o = wb4_rst_i ? g_addr : '0;
        s_data_o = wb4_rst_i ? g_data : '0;
        s_sel_o  = wb4_rst_i ? g_sel : '0;
        m_data_o = wb4_rst_i ? s_data_i : '0;
    end

    // State registers; reset gives master 0 first priority.
    always_ff @(posedge wb4_clk_i or negedge wb4_rst_i) begin
        if (!wb4_rst_i) begin
            state <= ST_IDLE;
            gnt   <= '0;
            last  <= LAST_RST;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            last  <= last_nxt;
            pend  <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_wb4_arbiter.sv
// Bench for wb4_arbiter: grant-selection table plus scripted bus sequences.
// A behavioural slave acks two cycles after each accept unless held off.
// Forwarded acks are checked against a scoreboard of expected master/data pairs.
module tb_wb4_arbiter;

    localparam int AW = 32;
    localparam int MC = 4;
    localparam int MP = 4;
    localparam int SW = AW / 8;
    localparam logic [31:0] MAGIC = 32'h5A5A_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [MC-1:0] cyc, stb, we;
    logic [AW-1:0] ma [MC];
    logic [AW-1:0] md [MC];
    logic [SW-1:0] msel [MC];
    logic [MC*AW-1:0] m_addr_flat, m_data_flat;
    logic [MC*SW-1:0] m_sel_flat;

    logic [MC-1:0] m_stall_o, m_ack_o;
    logic [AW-1:0] m_data_o, s_addr_o, s_data_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [SW-1:0] s_sel_o;

    logic          sstall;
    logic          sl_ack  = 1'b0;
    logic [AW-1:0] sl_data = 32'hDEAD_BEEF;
    logic          frc_ack;
    logic          sl_hold;
    logic          s_ack;
    assign s_ack = sl_ack | frc_ack;

    always_comb begin
        for (int k = 0; k < MC; k++) begin
            m_addr_flat[k*AW +: AW] = ma[k];
            m_data_flat[k*AW +: AW] = md[k];
            m_sel_flat[k*SW +: SW]  = msel[k];
        end
    end

    wb4_arbiter #(.ARCHBITSZ(AW), .MASTERCOUNT(MC), .MAXPENDING(MP)) dut (
        .wb4_clk_i (clk),
        .wb4_rst_i (rst_n),
        .m_cyc_i   (cyc),
        .m_stb_i   (stb),
        .m_we_i    (we),
        .m_addr_i  (m_addr_flat),
        .m_data_i  (m_data_flat),
        .m_sel_i   (m_sel_flat),
        .m_stall_o (m_stall_o),
        .m_ack_o   (m_ack_o),
        .m_data_o  (m_data_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_sel_o   (s_sel_o),
        .s_stall_i (sstall),
        .s_ack_i   (s_ack),
        .s_data_i  (sl_data)
    );

    typedef struct {int due; logic [31:0] d;} sl_ent_t;
    typedef struct {int m; logic [31:0] d;} sb_ent_t;
    sl_ent_t sl_q[$];
    sb_ent_t sb_q[$];

    int cyc_n  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [MC-1:0] oh(input int k);
        oh    = '0;
        oh[k] = 1'b1;
    endfunction

    // Slave response driver: one ack per cycle once the entry is due.
    always @(posedge clk) begin
        cyc_n = cyc_n + 1;
        #1;
        if (!sl_hold && sl_q.size() > 0 && sl_q[0].due <= cyc_n) begin
            sl_ack  = 1'b1;
            sl_data = sl_q[0].d;
            void'(sl_q.pop_front());
        end else begin
            sl_ack = 1'b0;
        end
    end

    // Slave request capture: an accept happens at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && s_cyc_o && s_stb_o && !sstall) begin
            sl_q.push_back('{cyc_n + 2, s_addr_o ^ MAGIC});
        end
    end

    // Ack monitor: every forwarded ack must match the oldest expected entry.
    always @(negedge clk) begin
        sb_ent_t e;
        logic [MC-1:0] em;
        if (m_ack_o != '0) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ack_unexpected: m_ack_o=%b, required no ack at %0t", m_ack_o, $time);
            end else begin
                e  = sb_q.pop_front();
                em = oh(e.m);
                chk("ack_master", m_ack_o, em);
                chk("ack_data", m_data_o, e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic w, input bit push, output int t);
        bit done;
        done    = 1'b0;
        t       = 0;
        ma[k]   = a;
        md[k]   = ~a;
        msel[k] = a[7:4];
        we[k]   = w;
        stb[k]  = 1'b1;
        if (push) sb_q.push_back('{k, a ^ MAGIC});
        while (!done && t < 40) begin
            @(negedge clk);
            if (!m_stall_o[k]) begin
                done = 1'b1;
                chk("issue_we", s_we_o, w);
                chk("issue_wdata", s_data_o, md[k]);
                chk("issue_sel", s_sel_o, msel[k]);
            end
            @(posedge clk);
            #1;
            t++;
        end
        stb[k] = 1'b0;
        chk("issue_accept", done, 1);
    endtask

    task automatic wait_grant(input int g, output int n);
        bit got;
        logic [MC-1:0] em;
        got = 1'b0;
        n   = 0;
        em  = ~oh(g);
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (m_stall_o != '1) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("grant_mask", m_stall_o, em);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sb(input string nm);
        int t;
        t = 0;
        while ((sb_q.size() != 0 || sl_q.size() != 0) && t < 60) begin
            tick();
            t++;
        end
        chk(nm, sb_q.size() + sl_q.size(), 0);
    endtask

    typedef struct {
        logic [MC-1:0] cyc;
        logic          stall;
        logic [MC-1:0] exp_stall;
        logic [31:0]   exp_addr;
    } vec_t;
    vec_t vt [6];

    initial begin
        int n, t;
        int ord [4];

        vt[0] = '{4'b0001, 1'b0, 4'b1110, 32'h100};
        vt[1] = '{4'b0110, 1'b0, 4'b1101, 32'h200};
        vt[2] = '{4'b1000, 1'b0, 4'b0111, 32'h400};
        vt[3] = '{4'b1100, 1'b0, 4'b1011, 32'h300};
        vt[4] = '{4'b1111, 1'b0, 4'b1110, 32'h100};
        vt[5] = '{4'b0100, 1'b1, 4'b1111, 32'h300};
        ord   = '{0, 1, 3, 0};

        // Reset with every input active: outputs must still show reset values.
        rst_n   = 1'b0;
        cyc     = '1;
        stb     = '1;
        we      = '1;
        sstall  = 1'b0;
        frc_ack = 1'b1;
        sl_hold = 1'b0;
        for (int k = 0; k < MC; k++) begin
            ma[k]   = 32'h100 * (k + 1);
            md[k]   = 32'hCAFE_0000 + k;
            msel[k] = 4'hF;
        end
        #12;
        chk("rst_s_cyc", s_cyc_o, 0);
        chk("rst_s_stb", s_stb_o, 0);
        chk("rst_s_we", s_we_o, 0);
        chk("rst_m_stall", m_stall_o, 4'hF);
        chk("rst_m_ack", m_ack_o, 0);
        chk("rst_s_addr", s_addr_o, 0);
        chk("rst_s_data", s_data_o, 0);
        chk("rst_s_sel", s_sel_o, 0);
        chk("rst_m_data", m_data_o, 0);
        cyc     = '0;
        stb     = '0;
        we      = '0;
        frc_ack = 1'b0;
        tick();
        rst_n = 1'b1;

        // Grant selection from reset priority (last owner = 3).
        for (int i = 0; i < 6; i++) begin
            do_reset();
            sstall = vt[i].stall;
            cyc    = vt[i].cyc;
            tick();
            @(negedge clk);
            chk("tbl_s_cyc", s_cyc_o, 1);
            chk("tbl_stall", m_stall_o, vt[i].exp_stall);
            chk("tbl_addr", s_addr_o, vt[i].exp_addr);
            cyc    = '0;
            sstall = 1'b0;
            tick();
            tick();
        end

        // Single master 2: three pipelined reads.
        do_reset();
        cyc[2] = 1'b1;
        issue(2, 32'h10, 1'b0, 1'b1, t);
        chk("first_accept_cycles", t, 2);
        issue(2, 32'h14, 1'b0, 1'b1, t);
        chk("pipelined_accept", t, 1);
        issue(2, 32'h18, 1'b0, 1'b1, t);
        chk("pipelined_accept", t, 1);
        wait_sb("single_acks");
        cyc[2] = 1'b0;
        tick();
        @(negedge clk);
        chk("single_idle_stall", m_stall_o, 4'hF);
        chk("single_idle_cyc", s_cyc_o, 0);

        // Spurious acks in IDLE and in GRANT.
        tick();
        frc_ack = 1'b1;
        @(negedge clk);
        chk("spur_idle_ack", m_ack_o, 0);
        frc_ack = 1'b0;
        cyc[0]  = 1'b1;
        wait_grant(0, n);
        frc_ack = 1'b1;
        @(negedge clk);
        chk("spur_grant_ack", m_ack_o, 0);
        frc_ack = 1'b0;
        cyc[0]  = 1'b0;
        tick();
        @(negedge clk);
        chk("spur_pend_zero", s_cyc_o, 0);
        tick();

        // Round-robin among masters 0, 1, 3; master 0 re-requests.
        do_reset();
        cyc = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            wait_grant(ord[i], n);
            if (i > 0) chk("rr_gap", n, 2);
            if (i == 1) cyc[0] = 1'b1;
            issue(ord[i], 32'h200 + 32'(i * 4), 1'b1, 1'b1, t);
            wait_sb("rr_ack");
            cyc[ord[i]] = 1'b0;
            tick();
        end

        // Outstanding limit with the slave holding its acks.
        do_reset();
        sl_hold = 1'b1;
        cyc[1]  = 1'b1;
        wait_grant(1, n);
        for (int j = 0; j < 4; j++) issue(1, 32'h300 + 32'(j * 4), 1'b1, 1'b1, t);
        stb[1] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("full_stall", m_stall_o[1], 1);
            chk("full_stb", s_stb_o, 0);
            @(posedge clk);
            #1;
        end
        chk("full_accepts", sl_q.size(), 4);
        sl_hold = 1'b0;
        issue(1, 32'h310, 1'b1, 1'b1, t);
        wait_sb("full_acks");
        cyc[1] = 1'b0;
        tick();
        tick();

        // Drain: master 1 leaves with two outstanding, master 0 waits.
        do_reset();
        sl_hold = 1'b1;
        cyc[1]  = 1'b1;
        wait_grant(1, n);
        cyc[0] = 1'b1;
        issue(1, 32'h400, 1'b0, 1'b0, t);
        issue(1, 32'h404, 1'b0, 1'b0, t);
        cyc[1] = 1'b0;
        @(negedge clk);
        chk("drop_cyc", s_cyc_o, 0);
        chk("drop_stb", s_stb_o, 0);
        tick();
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            chk("drain_cyc", s_cyc_o, 1);
            chk("drain_stb", s_stb_o, 0);
            chk("drain_stall", m_stall_o, 4'hF);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        sl_hold = 1'b0;
        wait_grant(0, n);
        chk("drain_grant_wait", n, 4);
        chk("drain_done_first", sl_q.size(), 0);
        cyc[0] = 1'b0;
        tick();
        tick();

        // Asynchronous reset with three requests outstanding.
        do_reset();
        sl_hold = 1'b1;
        cyc[2]  = 1'b1;
        wait_grant(2, n);
        for (int j = 0; j < 3; j++) issue(2, 32'h500 + 32'(j * 4), 1'b0, 1'b0, t);
        stb[2] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s_cyc", s_cyc_o, 0);
        chk("arst_s_stb", s_stb_o, 0);
        chk("arst_m_stall", m_stall_o, 4'hF);
        chk("arst_m_ack", m_ack_o, 0);
        chk("arst_s_addr", s_addr_o, 0);
        stb[2] = 1'b0;
        cyc[0] = 1'b1;
        #2;
        rst_n   = 1'b1;
        sl_hold = 1'b0;
        wait_grant(0, n);
        t = 0;
        while (sl_q.size() != 0 && t < 20) begin
            tick();
            t++;
        end
        tick();
        chk("arst_stale_flushed", sl_q.size(), 0);
        cyc = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/wb4_arbiter.md
# wb4_arbiter

Shares one pipelined Wishbone B4 slave port among MASTERCOUNT Wishbone B4 masters, such as several pi1q_to_wb4 bridges driving a single memory or peripheral bus. Arbitration is round-robin at bus-cycle granularity: once granted, a master keeps the slave for its whole CYC assertion. Any acks still outstanding when the owner drops CYC are drained before the next grant, so acknowledgements are never delivered to the wrong master.

## Interface
- ARCHBITSZ, 32, data/address width; 16, 32, 64, 128 or 256.
- MASTERCOUNT, 4, number of masters; 2..8.
- MAXPENDING, 4, maximum accepted-but-unacked requests; 1..15.

Ports:
- wb4_clk_i  in  1  clock; all logic on rising edge.
- wb4_rst_i  in  1  reset, asynchronous, active-low.
- m_cyc_i  in  MASTERCOUNT  per-master CYC.
- m_stb_i  in  MASTERCOUNT  per-master STB.
- m_we_i  in  MASTERCOUNT  per-master WE.
- m_addr_i  in  MASTERCOUNT*ARCHBITSZ  flattened addresses; master k at [k*ARCHBITSZ +: ARCHBITSZ].
- m_data_i  in  MASTERCOUNT*ARCHBITSZ  flattened write data.
- m_sel_i  in  MASTERCOUNT*(ARCHBITSZ/8)  flattened byte selects.
- m_stall_o  out  MASTERCOUNT  per-master STALL.
- m_ack_o  out  MASTERCOUNT  per-master ACK.
- m_data_o  out  ARCHBITSZ  read data, s_data_i broadcast to all masters.
- s_cyc_o, s_stb_o, s_we_o  out  1  slave CYC, STB, WE.
- s_addr_o, s_data_o  out  ARCHBITSZ  slave address and write data.
- s_sel_o  out  ARCHBITSZ/8  slave byte selects.
- s_stall_i, s_ack_i  in  1  slave STALL, ACK.
- s_data_i  in  ARCHBITSZ  slave read data.

## Operation
- Registered state: state (IDLE, GRANT, DRAIN), gnt index, last index, pend counter (clog2(MAXPENDING+1) bits).
- **IDLE**
  - s_cyc_o=0, s_stb_o=0.
  - All m_stall_o=1, all m_ack_o=0.
  - If any m_cyc_i is set, select the first set bit searching from (last+1) mod MASTERCOUNT upward with wrap-around.
  - Load gnt and last with that index; go to GRANT.
- **GRANT**
  - Outputs are combinational muxes of master gnt: s_cyc_o=1, s_we_o, s_addr_o, s_data_o, s_sel_o.
  - s_stb_o = m_stb_i[gnt] && pend!=MAXPENDING.
  - m_stall_o[gnt] = s_stall_i || pend==MAXPENDING. All other masters stall=1, ack=0.
  - m_ack_o[gnt] = s_ack_i && pend!=0.
  - Accept event = s_stb_o && !s_stall_i. Ack event = s_ack_i && pend!=0.
  - pend += accept − ack; a simultaneous accept and ack leaves pend unchanged.
  - If m_cyc_i[gnt]=0: s_cyc_o=0 and s_stb_o=0 in that same cycle. Next state is IDLE if pend (after the update) is 0, otherwise DRAIN.
- **DRAIN**
  - s_cyc_o=1, s_stb_o=0, all m_stall_o=1, all m_ack_o=0.
  - Acks decrement pend and are absorbed.
  - Go to IDLE on the cycle pend reaches 0.
- s_ack_i while pend==0 is spurious: ignored in every state, never forwarded.
- Idle slave outputs drive 0, except s_addr_o/s_data_o/s_sel_o, which follow master gnt.
- On reset:
  - state=IDLE, pend=0, gnt=0, last=MASTERCOUNT−1, so master 0 has first priority.
  - Every output is 0, except m_stall_o, which is all 1s.

## Timing
- Grant latency: a request raised at IDLE edge n gives s_cyc_o=1 and m_stall_o[gnt] follows s_stall_i after edge n+1. Minimum one cycle of stall before the first accept.
- Back-to-back ownership: after the owner drops CYC with pend=0, the next master is chosen in IDLE one cycle later. Minimum bus gap is 1 idle cycle.
- Throughput: one accepted request per cycle while pend<MAXPENDING and s_stall_i=0.
- Ack-to-master path: s_ack_i → m_ack_o and s_data_i → m_data_o are combinational, with 0 added latency.
- A non-owner raising CYC mid-ownership waits until ownership and any drain have completed. No preemption.
- Asynchronous reset mid-transaction: all state clears immediately. Outstanding slave responses arriving after reset release are discarded because pend=0.

## Test plan
- Single master: master 2 alone issues 3 pipelined reads to addresses 0x10, 0x14, 0x18; slave acks 2 cycles after each accept. Expect the first s_stb_o one cycle after cyc, 3 m_ack_o[2] pulses with matching data, m_ack_o[0,1,3] stay 0, and IDLE after cyc drops.
- Round-robin: masters 0, 1 and 3 hold cyc continuously, each releasing after one write. Expect grant order 0, 1, 3, 0, with one IDLE cycle between owners.
- MAXPENDING=2 with the slave never acking: master writes 4 times. Expect exactly 2 accepts, then m_stall_o[gnt]=1 and s_stb_o=0 until an ack arrives; pend never exceeds 2.
- Drain: master 1 drops cyc with pend=2. Expect s_cyc_o=0 that cycle, then DRAIN with s_cyc_o=1 and s_stb_o=0. The 2 late acks are not forwarded; master 0 waiting is granted only after pend=0 and one IDLE cycle.
- Spurious ack: s_ack_i=1 while pend=0 in GRANT and in IDLE. Expect no m_ack_o and pend stays 0.
- Reset: assert wb4_rst_i=0 mid-burst with pend=3 asynchronously. Expect all outputs at reset values without waiting for a clock edge; after release, master 0 has priority.
